// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO read side and the UART transmitter.
//   enable     : permits starting a new frame
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO registered read data (valid one cycle after the pop)
//   fifo_rd_en : single-cycle pop request to the FIFO
//   tx         : serial line, idle high
//   busy       : transmitter not idle
//   frame_done : pulse on the final cycle of the last stop bit
// The slave modport is the transmitter's view; master is the environment's.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, frame_done
  );

  modport slave (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage + UART serializer. Pops one word when enabled and the FIFO
// is non-empty, then sends start bit, data LSB first, optional even parity and
// 1 or 2 stop bits.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : fifo_uart_tx_if.slave (enable/fifo_empty/fifo_data in,
//         fifo_rd_en/tx/busy/frame_done out)
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t                state, state_nx;
  logic [BW-1:0]         baud;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity;
  logic                  baud_end;
  logic                  timed;

  assign baud_end = (baud == BAUD_MAX);
  // only the line-driving states count bit periods
  assign timed = (state == START) || (state == DATA) ||
                 (state == PARITY) || (state == STOP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.tx          = 1'b1;
    bus.fifo_rd_en  = 1'b0;
    bus.frame_done  = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      IDLE:   if (bus.enable && !bus.fifo_empty) state_nx = FETCH;
      FETCH: begin
        bus.fifo_rd_en = 1'b1;
        state_nx       = LOAD;
      end
      LOAD:   state_nx = START;
      START: begin
        bus.tx = 1'b0;
        if (baud_end) state_nx = DATA;
      end
      DATA: begin
        bus.tx = shift_reg[0];
        if (baud_end && bit_cnt == DATA_LAST)
          state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        bus.tx = parity;
        if (baud_end) state_nx = STOP;
      end
      STOP: begin
        if (baud_end && bit_cnt == STOP_LAST) begin
          bus.frame_done = 1'b1;
          state_nx       = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters clear on every state change; bit_cnt counts data bits in DATA
  // and stop-bit periods in STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud      <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
    end else begin
      if (state_nx != state) begin
        baud    <= '0;
        bit_cnt <= '0;
      end else if (timed) begin
        if (baud_end) begin
          baud    <= '0;
          bit_cnt <= bit_cnt + CW'(1);
        end else begin
          baud    <= baud + BW'(1);
        end
      end
      if (state == LOAD) begin
        shift_reg <= bus.fifo_data;
        parity    <= ^bus.fifo_data;
      end else if (state == DATA && baud_end) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (no parity / 1 stop, even parity / 2 stops) fed by
// queue-based FIFO models, checked cycle by cycle against a frame-level model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       push_vld = 1'b0;
  logic [7:0] push_dat = 8'h00;
  bit         armed = 1'b0;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level of bit slot idx within a frame carrying word w.
  function automatic logic frame_bit(input logic [7:0] w, input int idx, input int par);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (par != 0 && idx == DW + 1) return ^w;
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int PAR = gi;
    localparam int STP = gi + 1;
    localparam int FLEN = (1 + DW + PAR + STP) * CPB;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    logic [7:0] fq[$];
    int         fsize = 0;
    int         pops = 0;
    logic [7:0] fdata = 8'h00;

    // model: m_pos counts cycles from the pop cycle of the current frame
    bit         m_busy = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_word = 8'h00;
    int         k;
    logic       ex_tx;

    assign bus.enable     = en;
    assign bus.fifo_empty = (fsize == 0);
    assign bus.fifo_data  = fdata;
    assign k     = m_pos - 2;
    assign ex_tx = (m_busy && k >= 0) ? frame_bit(m_word, k / CPB, PAR) : 1'b1;

    fifo_uart_tx #(
      .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PAR), .STOP_BITS(STP)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always @(posedge clk) begin
      if (bus.fifo_rd_en === 1'b1) begin
        if (fq.size() != 0) fdata <= fq.pop_front();
        pops <= pops + 1;
      end
      if (push_vld) fq.push_back(push_dat);
      fsize <= fq.size();
    end

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("u%0d_tx", gi), bus.tx, ex_tx);
        chk($sformatf("u%0d_busy", gi), bus.busy, m_busy);
        chk($sformatf("u%0d_rd_en", gi), bus.fifo_rd_en, m_busy && m_pos == 0);
        chk($sformatf("u%0d_done", gi), bus.frame_done, m_busy && k == FLEN - 1);
        if (rst) begin
          m_busy <= 1'b0;
        end else if (m_busy) begin
          if (k == FLEN - 1) m_busy <= 1'b0;
          else               m_pos  <= m_pos + 1;
        end else if (en && fsize != 0) begin
          m_busy <= 1'b1;
          m_pos  <= 0;
          m_word <= fq[0];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    push_vld = 1'b1;
    push_dat = w;
    step(1);
    push_vld = 1'b0;
  endtask

  int p0, p1;

  initial begin
    @(posedge clk);
    #1 armed = 1'b1;
    step(2);
    rst = 1'b0;
    en  = 1'b1;
    step(20);                       // idle with empty FIFO

    push(8'hA5); step(60);
    push(8'h07); step(70);
    push(8'h03); step(70);

    p0 = g_inst[0].pops; p1 = g_inst[1].pops;
    repeat (3) push(8'($urandom));
    step(200);
    chk("u0_burst_pops", g_inst[0].pops - p0, 3);
    chk("u1_burst_pops", g_inst[1].pops - p1, 3);
    chk("u0_burst_empty", g_inst[0].fsize, 0);
    chk("u1_burst_empty", g_inst[1].fsize, 0);

    p0 = g_inst[0].pops; p1 = g_inst[1].pops;
    push(8'h3C); push(8'hC3);
    step(8);
    en = 1'b0;
    step(100);
    chk("u0_hold_pops", g_inst[0].pops - p0, 1);
    chk("u1_hold_pops", g_inst[1].pops - p1, 1);
    chk("u0_hold_left", g_inst[0].fsize, 1);
    chk("u1_hold_left", g_inst[1].fsize, 1);
    en = 1'b1;
    step(80);

    push(8'h5A);
    step(14);                       // both units are shifting data bits
    rst = 1'b1; step(1); rst = 1'b0;
    step(20);
    push(8'h96); step(100);

    for (int i = 0; i < 400; i++) begin
      push_vld = ($urandom % 20) == 0;
      push_dat = 8'($urandom);
      if (($urandom % 25) == 0) en = ~en;
      rst = ($urandom % 150) == 0;
      step(1);
    end
    push_vld = 1'b0;
    rst = 1'b0;
    en  = 1'b1;
    step(1500);
    chk("u0_drained", g_inst[0].fsize, 0);
    chk("u1_drained", g_inst[1].fsize, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
